// File: rtl/pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// pipe_reg_chain
//
// Purpose:
//   Multi-stage register pipeline with valid/ready flow control for the
//   upscaler datapath. Each of the DEPTH stages holds a WIDTH-bit data word
//   and a valid bit. An empty stage (bubble) is always refilled from the
//   stage behind it, even while downstream stalls, so the chain only pushes
//   back upstream once every stage holds a word. A synchronous flush drops
//   every word in flight. A registered occupancy count tracks how many
//   stages hold valid words.
//
// Parameters:
//   WIDTH     - data bits per stage (>= 1)
//   DEPTH     - number of register stages (>= 1); latency when unstalled
//   RESET_VAL - value loaded into every data register on reset
//   CNT_W     - width of the occupancy output (derived from DEPTH)
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous clear of all stage valid bits
//   in_valid  in   upstream word present
//   in_data   in   upstream word (ignored when in_valid = 0)
//   in_ready  out  stage 0 can accept a word this cycle
//   out_valid out  last stage holds a word (registered)
//   out_data  out  last-stage word (registered)
//   out_ready in   downstream accepts the presented word
//   occupancy out  number of stages holding a valid word (registered)
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy
);

  // Stage storage. Index 0 is the input side, DEPTH-1 drives the outputs.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];

  // r[i] = stage i may load this cycle; r[DEPTH] is the downstream ready.
  logic [DEPTH:0]   r;
  logic             chain;

  // What each stage would load: the previous stage, or the upstream port.
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d [DEPTH];

  logic             accept;
  logic             deliver;
  logic [CNT_W-1:0] occ;

  // Ready chain, walked from the output side back to the input side.
  // A stage can load if it is empty or if the stage in front of it can
  // move on. Rather than feeding r back into itself, a running OR of
  // "some stage at or after i is empty, or downstream is ready" is
  // accumulated, which is the same function without a self-dependent
  // vector.
  always_comb begin
    chain    = out_ready;
    r        = '0;
    r[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      chain = chain | ~v[i];
      r[i]  = chain;
    end
  end

  // Source selection for every stage. Stage 0 takes the upstream port;
  // every later stage takes the stage just behind it.
  always_comb begin
    src_v    = '0;
    src_v[0] = in_valid;
    for (int i = 0; i < DEPTH; i++) begin
      src_d[i] = in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      src_v[i] = v[i-1];
      src_d[i] = d[i-1];
    end
  end

  // Handshake qualifiers. Flush masks in_ready so nothing is accepted in
  // the flush cycle; a delivery that coincides with a flush is overridden
  // by the flush clearing the occupancy count below.
  always_comb begin
    in_ready = r[0] & ~flush;
    accept   = in_valid & in_ready;
    deliver  = v[DEPTH-1] & out_ready;
  end

  // Valid bits. Flush clears every stage but leaves the data registers
  // alone. Otherwise a ready stage copies the valid bit of its source,
  // which is how bubbles travel forward and get squeezed out when the
  // head of the chain is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r[i]) begin
          v[i] <= src_v[i];
        end
      end
    end
  end

  // Data registers. A stage only captures data when a real word moves in,
  // so an empty bubble passing through never clobbers the last word seen.
  // This keeps out_data steady while the last stage is stalled or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (!flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (r[i] && src_v[i]) begin
          d[i] <= src_d[i];
        end
      end
    end
  end

  // Occupancy counter. It moves up on an accept alone and down on a
  // delivery alone; an accept and a delivery in the same cycle cancel.
  // Flush wins over both and empties the count together with the valid
  // bits, so the count always matches the number of set valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (accept && !deliver) begin
      occ <= occ + CNT_W'(1);
    end else if (deliver && !accept) begin
      occ <= occ - CNT_W'(1);
    end
  end

  // Registered outputs come straight from the last stage.
  always_comb begin
    out_valid = v[DEPTH-1];
    out_data  = d[DEPTH-1];
    occupancy = occ;
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg_chain
//
// Purpose:
//   Self-checking bench for pipe_reg_chain with WIDTH=8, DEPTH=3 and
//   RESET_VAL=8'hA5. Directed stimulus pushes every accepted word into an
//   expected-order queue; a monitor pops and compares on every delivery.
//   Flush and reset empty the queue, so any word that should have been
//   discarded shows up as an unexpected output.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CNT_W-1:0] occupancy;

  int               checks;
  int               failures;
  int               delivered;
  logic [WIDTH-1:0] sb [$];

  pipe_reg_chain #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'hA5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a mismatch on a single line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, wait for the edge, settle just after it.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] dat,
                               input logic rdy, input logic fl);
    in_valid  = v;
    in_data   = dat;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor. Samples on the falling edge, where inputs are
  // stable for the coming rising edge. Deliveries are compared against the
  // head of the queue first, then any accept is appended, so a word can
  // never be matched against itself in the same cycle.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output: got %0h, expected no word", out_data);
        end else begin
          checkOutput("out_data", 32'(out_data), 32'(sb.pop_front()));
          delivered++;
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
      end
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    delivered = 0;
    rst_n     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset asserts before any clock edge: outputs must follow at once.
    #1 rst_n = 1'b0;
    #1;
    $display("[TB] reset");
    checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_out_data",  32'(out_data),  32'hA5);
    checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
    checkOutput("rst_in_ready",  32'(in_ready),  32'h1);

    // Release mid-cycle (between the falling edge at 20 and rising at 25).
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_out_valid", 32'(out_valid), 32'h0);
    checkOutput("post_rst_out_data",  32'(out_data),  32'hA5);
    checkOutput("post_rst_occupancy", 32'(occupancy), 32'h0);

    // Streaming 01..10 with downstream always ready.
    $display("[TB] streaming");
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 8'(k + 1), 1'b1, 1'b0);
      if (k == 0) begin
        checkOutput("stream_lat_e0_valid", 32'(out_valid), 32'h0);
        checkOutput("stream_occ_e0",       32'(occupancy), 32'h1);
      end
      if (k == 1) begin
        checkOutput("stream_lat_e1_valid", 32'(out_valid), 32'h0);
        checkOutput("stream_occ_e1",       32'(occupancy), 32'h2);
      end
      if (k == 2) begin
        checkOutput("stream_lat_e2_valid", 32'(out_valid), 32'h1);
        checkOutput("stream_lat_e2_data",  32'(out_data),  32'h01);
      end
      if (k == 8) begin
        checkOutput("stream_occ_mid",      32'(occupancy), 32'h3);
        checkOutput("stream_in_ready_mid", 32'(in_ready),  32'h1);
      end
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_delivered", 32'(delivered), 32'd16);
    checkOutput("stream_occ_end",   32'(occupancy), 32'h0);

    // Backpressure with a bubble: the chain squeezes it out and only
    // pushes back once three words are held.
    $display("[TB] backpressure");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    checkOutput("bp_occ_1",   32'(occupancy), 32'h1);
    checkOutput("bp_ready_1", 32'(in_ready),  32'h1);
    applyStimulus(1'b0, 8'hEE, 1'b0, 1'b0);
    checkOutput("bp_occ_idle",   32'(occupancy), 32'h1);
    checkOutput("bp_ready_idle", 32'(in_ready),  32'h1);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    checkOutput("bp_occ_2",   32'(occupancy), 32'h2);
    checkOutput("bp_ready_2", 32'(in_ready),  32'h1);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    checkOutput("bp_occ_3",   32'(occupancy), 32'h3);
    checkOutput("bp_ready_3", 32'(in_ready),  32'h0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("bp_stall_occ",   32'(occupancy), 32'h3);
    checkOutput("bp_stall_valid", 32'(out_valid), 32'h1);
    checkOutput("bp_stall_data",  32'(out_data),  32'h11);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("bp_stable_data", 32'(out_data),  32'h11);
    applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
    checkOutput("bp_release_occ", 32'(occupancy), 32'h3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("bp_delivered", 32'(delivered), 32'd20);
    checkOutput("bp_occ_end",   32'(occupancy), 32'h0);

    // Full chain with accept and deliver in the same cycle.
    $display("[TB] full pass-through");
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    checkOutput("full_occ",      32'(occupancy), 32'h3);
    checkOutput("full_ready_lo", 32'(in_ready),  32'h0);
    out_ready = 1'b1;
    #1;
    checkOutput("full_ready_hi", 32'(in_ready),  32'h1);
    applyStimulus(1'b1, 8'h88, 1'b1, 1'b0);
    checkOutput("full_occ_a", 32'(occupancy), 32'h3);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b0);
    checkOutput("full_occ_b", 32'(occupancy), 32'h3);
    applyStimulus(1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("full_occ_c", 32'(occupancy), 32'h3);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("full_delivered", 32'(delivered), 32'd26);
    checkOutput("full_occ_end",   32'(occupancy), 32'h0);

    // Flush with an accept and a ready downstream in the same cycle.
    $display("[TB] flush");
    applyStimulus(1'b1, 8'hBB, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hCC, 1'b0, 1'b0);
    checkOutput("flush_occ_pre", 32'(occupancy), 32'h2);
    in_valid  = 1'b1;
    in_data   = 8'hDD;
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    checkOutput("flush_occ_post",   32'(occupancy), 32'h0);
    checkOutput("flush_valid_post", 32'(out_valid), 32'h0);
    applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
    checkOutput("flush_next_occ", 32'(occupancy), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_next_e1_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_next_e2_valid", 32'(out_valid), 32'h1);
    checkOutput("flush_next_e2_data",  32'(out_data),  32'hEE);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("flush_occ_end", 32'(occupancy), 32'h0);

    // Asynchronous reset pulse while the chain is full and stalled.
    $display("[TB] async reset mid-stall");
    applyStimulus(1'b1, 8'hF1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF3, 1'b0, 1'b0);
    checkOutput("ar_occ_pre", 32'(occupancy), 32'h3);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("ar_out_valid", 32'(out_valid), 32'h0);
    checkOutput("ar_out_data",  32'(out_data),  32'hA5);
    checkOutput("ar_occupancy", 32'(occupancy), 32'h0);
    checkOutput("ar_in_ready",  32'(in_ready),  32'h1);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("ar_out_valid_after", 32'(out_valid), 32'h0);

    checkOutput("final_queue_empty", 32'(sb.size()), 32'h0);
    checkOutput("final_delivered",   32'(delivered),  32'd27);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
